register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register address width; register count is 2**ADDR_W.
REQ-002 SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads 16'h0000 and ignores writes.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on posedge CLK.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port REGA_EN  input  1  port A access enable from the register sequencer.
REQ-006 SHALL have port REGA_WEN  input  1  port A write request.
REQ-007 SHALL have port REGA_BYTE_EN  input  2  port A lane enables: 00 none, 01 low, 10 high, 11 both.
REQ-008 SHALL have port REGB_EN  input  1  port B access enable.
REQ-009 SHALL have port REGB_WEN  input  1  port B write request; always full word.
REQ-010 SHALL have port ADDRA  input  ADDR_W  port A register select.
REQ-011 SHALL have port ADDRB  input  ADDR_W  port B register select.
REQ-012 SHALL have port DINA  input  16  port A write data, lanes aligned: [15:8] high, [7:0] low.
REQ-013 SHALL have port DINB  input  16  port B write data.
REQ-014 SHALL have port DOUTA  output  16  registered port A read data.
REQ-015 SHALL have port DOUTB  output  16  registered port B read data.
REQ-016 SHALL have port WR_DONE  output  1  one-cycle pulse marking the cycle a write commits.

Function
REQ-017 Storage SHALL be 2**ADDR_W words of 16 bits.
REQ-018 Write arming: per port, a write commits only on the first posedge where EN=1 and WEN=1 while that port's previous-cycle WEN sample was 0; it SHALL NOT repeat while WEN stays high.
REQ-019 The WEN history register SHALL sample EN&WEN every posedge; EN low clears it.
REQ-020 Port A write SHALL update only lanes whose REGA_BYTE_EN bit is 1; BYTE_EN=00 with WEN=1 commits nothing and gives no WR_DONE.
REQ-021 Port B write SHALL update all 16 bits of register ADDRB.
REQ-022 On a same-cycle A and B commit to the same address, B SHALL be applied first and A's enabled lanes SHALL overlay it.
REQ-023 WR_DONE SHALL be 1 for exactly the cycle after any write commits, else 0.
REQ-024 While REGx_EN=1, DOUTx SHALL load every posedge with the post-write value of the addressed register (write-through, including the other port's write in the same cycle).
REQ-025 Port A byte read: BYTE_EN=01 gives {8'h00, reg[7:0]}; 10 gives {8'h00, reg[15:8]}; 11 gives the full word; 00 holds DOUTA.
REQ-026 While REGx_EN=0, DOUTx SHALL hold its last value.
REQ-027 ZERO_R0=1: address 0 SHALL read 16'h0000, ignore writes and still pulse WR_DONE on an armed commit.
REQ-028 Address values SHALL be used unmodified, with no wrap or range check; all 2**ADDR_W addresses are valid.

Reset
REQ-029 With RESET_N low, all registers SHALL be 16'h0000, DOUTA=DOUTB=16'h0000, WR_DONE=0 and the WEN history cleared, immediately and without a clock.
REQ-030 A reset asserted mid-write SHALL abort the write; after release the write requires a fresh 0->1 WEN edge.
REQ-031 Reset release SHALL take effect at the first posedge with RESET_N high.

Verification
REQ-032 Word write: A EN=1, WEN 0->1, ADDRA=3, BYTE_EN=11, DINA=16'hBEEF -> R3=BEEF, WR_DONE pulses once; DINA changed to 1234 with WEN held high -> R3 stays BEEF.
REQ-033 Byte lanes: R5=16'h1122, A write with BYTE_EN=10, DINA=16'hAAxx -> R5=AA22; a read of R5 with BYTE_EN=01 -> DOUTA=0022.
REQ-034 Collision: A (BYTE_EN=01, DINA=00CC) and B (DINB=7788) commit to R7 in the same cycle -> R7=77CC, and both DOUTs read 77CC that cycle.
REQ-035 Write-through: B writes R2=16'h5A5A while A reads R2 in the same cycle -> DOUTA=5A5A.
REQ-036 Reset mid-operation: RESET_N pulsed low with WEN high -> all registers and outputs 0; after release with WEN still high -> no write occurs until WEN goes low then high.
REQ-037 ZERO_R0=1: write 16'hFFFF to R0 -> read of R0 returns 0000, WR_DONE pulses.

Source files
------------

// File: rtl/register_file_if.sv
// Register file bus: port A (byte-lane capable) and port B (word only) access
// signals, plus the registered read data and write-commit pulse.
interface register_file_if #(
    parameter int ADDR_W = 4
);
    logic              REGA_EN;
    logic              REGA_WEN;
    logic [1:0]        REGA_BYTE_EN;
    logic              REGB_EN;
    logic              REGB_WEN;
    logic [ADDR_W-1:0] ADDRA;
    logic [ADDR_W-1:0] ADDRB;
    logic [15:0]       DINA;
    logic [15:0]       DINB;
    logic [15:0]       DOUTA;
    logic [15:0]       DOUTB;
    logic              WR_DONE;

    modport master (
        output REGA_EN, REGA_WEN, REGA_BYTE_EN, REGB_EN, REGB_WEN,
        output ADDRA, ADDRB, DINA, DINB,
        input  DOUTA, DOUTB, WR_DONE
    );

    modport slave (
        input  REGA_EN, REGA_WEN, REGA_BYTE_EN, REGB_EN, REGB_WEN,
        input  ADDRA, ADDRB, DINA, DINB,
        output DOUTA, DOUTB, WR_DONE
    );
endinterface

// File: rtl/register_file.sv
// Dual-port 16-bit register file with edge-armed writes.
// Port A writes selected byte lanes, port B writes whole words; on a same
// address collision B lands first and A's lanes overlay it. Reads are
// registered and see the post-write value (write-through across ports).
// Storage is cleared by the asynchronous reset, so it is built from flops.
module register_file #(
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    register_file_if.slave    bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [15:0] mem_reg  [NREG];
    logic [15:0] mem_next [NREG];

    // hist_*: last cycle's EN&WEN sample. armed_*: a low sample has been seen
    // since reset, so a WEN held high across reset cannot commit on release.
    logic hist_a_reg;
    logic hist_b_reg;
    logic armed_a_reg;
    logic armed_b_reg;

    logic sample_a;
    logic sample_b;
    logic commit_a;
    logic commit_b;

    logic [15:0] douta_reg;
    logic [15:0] douta_next;
    logic [15:0] doutb_reg;
    logic [15:0] doutb_next;
    logic        wr_done_reg;
    logic [15:0] word_a;

    assign sample_a = bus.REGA_EN & bus.REGA_WEN;
    assign sample_b = bus.REGB_EN & bus.REGB_WEN;

    // A port-A request with no lanes enabled is not a commit at all.
    assign commit_a = sample_a & ~hist_a_reg & armed_a_reg & (bus.REGA_BYTE_EN != 2'b00);
    assign commit_b = sample_b & ~hist_b_reg & armed_b_reg;

    // Post-write image of every register: B word first, then A lanes on top.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_next[i] = mem_reg[i];
            if (commit_b && (bus.ADDRB == ADDR_W'(i))) begin
                mem_next[i] = bus.DINB;
            end
            if (commit_a && (bus.ADDRA == ADDR_W'(i))) begin
                if (bus.REGA_BYTE_EN[0]) begin
                    mem_next[i][7:0] = bus.DINA[7:0];
                end
                if (bus.REGA_BYTE_EN[1]) begin
                    mem_next[i][15:8] = bus.DINA[15:8];
                end
            end
            if (ZERO_R0 && (i == 0)) begin
                mem_next[i] = 16'h0000;
            end
        end
    end

    // Read data selection; a write access returns the full post-write word,
    // a plain read formats by lane and BYTE_EN=00 leaves DOUTA untouched.
    always_comb begin
        word_a     = mem_next[bus.ADDRA];
        douta_next = douta_reg;
        doutb_next = doutb_reg;
        if (bus.REGA_EN) begin
            if (bus.REGA_WEN) begin
                douta_next = word_a;
            end else begin
                case (bus.REGA_BYTE_EN)
                    2'b01:   douta_next = {8'h00, word_a[7:0]};
                    2'b10:   douta_next = {8'h00, word_a[15:8]};
                    2'b11:   douta_next = word_a;
                    default: douta_next = douta_reg;
                endcase
            end
        end
        if (bus.REGB_EN) begin
            doutb_next = mem_next[bus.ADDRB];
        end
    end

    // Register storage update.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= mem_next[i];
            end
        end
    end

    // WEN history, arming, read registers and the commit pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_a_reg  <= 1'b0;
            hist_b_reg  <= 1'b0;
            armed_a_reg <= 1'b0;
            armed_b_reg <= 1'b0;
            douta_reg   <= 16'h0000;
            doutb_reg   <= 16'h0000;
            wr_done_reg <= 1'b0;
        end else begin
            hist_a_reg  <= sample_a;
            hist_b_reg  <= sample_b;
            armed_a_reg <= armed_a_reg | ~sample_a;
            armed_b_reg <= armed_b_reg | ~sample_b;
            douta_reg   <= douta_next;
            doutb_reg   <= doutb_next;
            wr_done_reg <= commit_a | commit_b;
        end
    end

    assign bus.DOUTA   = douta_reg;
    assign bus.DOUTB   = doutb_reg;
    assign bus.WR_DONE = wr_done_reg;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: two instances (ZERO_R0 = 0 and 1) share one
// stimulus stream; an array-based reference model predicts their outputs.
module tb_register_file;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLK = ~CLK;

    logic              a_en  = 1'b0;
    logic              a_wen = 1'b0;
    logic [1:0]        a_be  = 2'b00;
    logic              b_en  = 1'b0;
    logic              b_wen = 1'b0;
    logic [ADDR_W-1:0] addra = '0;
    logic [ADDR_W-1:0] addrb = '0;
    logic [15:0]       dina  = 16'h0000;
    logic [15:0]       dinb  = 16'h0000;

    register_file_if #(.ADDR_W(ADDR_W)) bus0 ();
    register_file_if #(.ADDR_W(ADDR_W)) bus1 ();

    assign bus0.REGA_EN = a_en;   assign bus1.REGA_EN = a_en;
    assign bus0.REGA_WEN = a_wen; assign bus1.REGA_WEN = a_wen;
    assign bus0.REGA_BYTE_EN = a_be; assign bus1.REGA_BYTE_EN = a_be;
    assign bus0.REGB_EN = b_en;   assign bus1.REGB_EN = b_en;
    assign bus0.REGB_WEN = b_wen; assign bus1.REGB_WEN = b_wen;
    assign bus0.ADDRA = addra;    assign bus1.ADDRA = addra;
    assign bus0.ADDRB = addrb;    assign bus1.ADDRB = addrb;
    assign bus0.DINA = dina;      assign bus1.DINA = dina;
    assign bus0.DINB = dinb;      assign bus1.DINB = dinb;

    register_file #(.ADDR_W(ADDR_W), .ZERO_R0(1'b0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus0)
    );
    register_file #(.ADDR_W(ADDR_W), .ZERO_R0(1'b1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus1)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    // Reference model: index 0 models ZERO_R0=0, index 1 models ZERO_R0=1.
    logic [15:0] m_mem   [2][NREG];
    logic [15:0] m_douta [2];
    logic [15:0] m_doutb [2];
    logic        m_wrd   [2];
    logic        m_prev_a, m_prev_b;   // previous EN&WEN sample per port
    logic        m_low_a,  m_low_b;    // a low sample seen since reset

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < NREG; r++) m_mem[z][r] = 16'h0000;
            m_douta[z] = 16'h0000;
            m_doutb[z] = 16'h0000;
            m_wrd[z]   = 1'b0;
        end
        m_prev_a = 1'b0; m_prev_b = 1'b0;
        m_low_a  = 1'b0; m_low_b  = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_step();
        bit ca, cb;
        logic [15:0] w;
        ca = a_en && a_wen && !m_prev_a && m_low_a && (a_be != 2'b00);
        cb = b_en && b_wen && !m_prev_b && m_low_b;
        for (int z = 0; z < 2; z++) begin
            if (cb && !(z == 1 && addrb == 0)) m_mem[z][addrb] = dinb;
            if (ca && !(z == 1 && addra == 0)) begin
                w = m_mem[z][addra];
                if (a_be[0]) w[7:0]  = dina[7:0];
                if (a_be[1]) w[15:8] = dina[15:8];
                m_mem[z][addra] = w;
            end
            m_wrd[z] = ca || cb;
            if (a_en) begin
                w = m_mem[z][addra];
                if (a_wen)              m_douta[z] = w;
                else if (a_be == 2'b01) m_douta[z] = {8'h00, w[7:0]};
                else if (a_be == 2'b10) m_douta[z] = {8'h00, w[15:8]};
                else if (a_be == 2'b11) m_douta[z] = w;
            end
            if (b_en) m_doutb[z] = m_mem[z][addrb];
        end
        m_prev_a = a_en && a_wen;
        m_prev_b = b_en && b_wen;
        m_low_a  = m_low_a || !(a_en && a_wen);
        m_low_b  = m_low_b || !(b_en && b_wen);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET_N) model_step();
        #1;
    endtask

    // Single compare process: every negedge, both instances against the model.
    always @(negedge CLK) begin
        if (cmp_on) begin
            check("dut0_douta", bus0.DOUTA, m_douta[0]);
            check("dut0_doutb", bus0.DOUTB, m_doutb[0]);
            check("dut0_wr_done", 16'(bus0.WR_DONE), 16'(m_wrd[0]));
            check("dut1_douta", bus1.DOUTA, m_douta[1]);
            check("dut1_doutb", bus1.DOUTB, m_doutb[1]);
            check("dut1_wr_done", 16'(bus1.WR_DONE), 16'(m_wrd[1]));
        end
    end

    task automatic reset_pulse();
        RESET_N = 1'b0;
        model_reset();
        #1;
        check("rst_douta", bus0.DOUTA, 16'h0000);
        check("rst_doutb", bus0.DOUTB, 16'h0000);
        check("rst_wr_done", 16'(bus0.WR_DONE), 16'h0000);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 RESET_N = 1'b0;
        #1;
        check("por_douta", bus0.DOUTA, 16'h0000);
        check("por_doutb", bus0.DOUTB, 16'h0000);
        check("por_wr_done", 16'(bus0.WR_DONE), 16'h0000);
        cmp_on = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Word write then held WEN with new data.
        a_en = 1'b1; a_wen = 1'b0; a_be = 2'b11; addra = 4'd3; tick();
        a_wen = 1'b1; dina = 16'hBEEF; tick();
        $display("txn A word write R3=BEEF");
        check("w32_wr_done", 16'(bus0.WR_DONE), 16'h0001);
        check("w32_douta", bus0.DOUTA, 16'hBEEF);
        check("w32_model_r3", m_mem[0][3], 16'hBEEF);
        dina = 16'h1234; tick();
        $display("txn A held WEN, DINA=1234");
        check("w32_hold_wr_done", 16'(bus0.WR_DONE), 16'h0000);
        check("w32_hold_douta", bus0.DOUTA, 16'hBEEF);

        // Byte lanes on R5.
        a_wen = 1'b0; tick();
        addra = 4'd5; a_wen = 1'b1; a_be = 2'b11; dina = 16'h1122; tick();
        $display("txn A word write R5=1122");
        check("b33_init", bus0.DOUTA, 16'h1122);
        a_wen = 1'b0; tick();
        a_wen = 1'b1; a_be = 2'b10; dina = 16'hAA99; tick();
        $display("txn A high-lane write R5");
        check("b33_wr_done", 16'(bus0.WR_DONE), 16'h0001);
        check("b33_word", bus0.DOUTA, 16'hAA22);
        a_wen = 1'b0; a_be = 2'b01; tick();
        $display("txn A low-lane read R5");
        check("b33_lo_read", bus0.DOUTA, 16'h0022);
        a_be = 2'b10; tick();
        $display("txn A high-lane read R5");
        check("b33_hi_read", bus0.DOUTA, 16'h00AA);
        a_be = 2'b00; tick();
        check("b33_be00_hold", bus0.DOUTA, 16'h00AA);

        // Collision on R7.
        b_en = 1'b1; b_wen = 1'b0; tick();
        a_wen = 1'b1; a_be = 2'b01; addra = 4'd7; dina = 16'h00CC;
        b_wen = 1'b1; addrb = 4'd7; dinb = 16'h7788; tick();
        $display("txn A+B collision R7");
        check("c34_douta", bus0.DOUTA, 16'h77CC);
        check("c34_doutb", bus0.DOUTB, 16'h77CC);
        check("c34_wr_done", 16'(bus0.WR_DONE), 16'h0001);

        // Write-through from B to an A read.
        a_wen = 1'b0; b_wen = 1'b0; tick();
        b_wen = 1'b1; addrb = 4'd2; dinb = 16'h5A5A; a_be = 2'b11; addra = 4'd2; tick();
        $display("txn B write R2, A read R2");
        check("t35_douta", bus0.DOUTA, 16'h5A5A);
        check("t35_doutb", bus0.DOUTB, 16'h5A5A);

        // Reset in the middle of a held write.
        b_wen = 1'b0; b_en = 1'b0; tick();
        a_wen = 1'b1; addra = 4'd9; a_be = 2'b11; dina = 16'h4444; tick();
        check("r36_pre", bus0.DOUTA, 16'h4444);
        dina = 16'h9999;
        #1 reset_pulse();
        $display("txn reset with WEN high");
        tick();
        check("r36_no_write", 16'(bus0.WR_DONE), 16'h0000);
        check("r36_cleared", bus0.DOUTA, 16'h0000);
        a_wen = 1'b0; tick();
        a_wen = 1'b1; tick();
        $display("txn fresh WEN edge after reset");
        check("r36_rearm_wr_done", 16'(bus0.WR_DONE), 16'h0001);
        check("r36_rearm_douta", bus0.DOUTA, 16'h9999);

        // Register 0 write on both variants.
        a_wen = 1'b0; tick();
        addra = 4'd0; a_wen = 1'b1; dina = 16'hFFFF; tick();
        $display("txn A write R0=FFFF");
        check("z37_dut1_douta", bus1.DOUTA, 16'h0000);
        check("z37_dut1_wr_done", 16'(bus1.WR_DONE), 16'h0001);
        check("z37_dut0_douta", bus0.DOUTA, 16'hFFFF);
        a_wen = 1'b0; tick();
        check("z37_dut1_read", bus1.DOUTA, 16'h0000);

        // Randomized traffic with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            a_en  = ($urandom_range(0, 3) != 0);
            a_wen = ($urandom_range(0, 1) == 1);
            a_be  = 2'($urandom_range(0, 3));
            addra = 4'($urandom_range(0, NREG - 1));
            dina  = 16'($urandom);
            b_en  = ($urandom_range(0, 3) != 0);
            b_wen = ($urandom_range(0, 1) == 1);
            addrb = ($urandom_range(0, 3) == 0) ? addra : 4'($urandom_range(0, NREG - 1));
            dinb  = 16'($urandom);
            if ($urandom_range(0, 299) == 0) reset_pulse();
            tick();
        end

        @(negedge CLK);
        #1 cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
